// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the single-cycle RV32 core.
// A small BOOT/RUN/HALT FSM chooses whether the PC holds or loads. In RUN the
// next PC is picked by priority: trap, halt, stall, mret, jalr, jump/branch,
// and finally pc+4. A redirect target that is not aligned is replaced by
// TRAP_VECTOR, the current PC is saved in mepc, and misaligned pulses for
// one cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   stall, halt, resume      hold / debug-halt / leave-halt controls
//   branch_taken, jump, jalr redirect requests (targets pc+imm, rs1+imm)
//   trap, mret               exception entry / return
//   imm, rs1                 immediate and JALR base register
//   pc, pcplus_4, pc_next    current, link (pc+4) and next fetch address
//   pc_valid, halted         decode of the FSM state (RUN / HALT)
//   misaligned               one-cycle pulse after a rejected target
//   mepc                     saved exception PC
//   adv_count                number of PC loads made while in RUN
//
// state | meaning
// BOOT  | first cycle after reset release, PC held, inputs ignored
// RUN   | fetching, PC advances or redirects
// HALT  | debug halt, PC held until resume
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int              ALIGN_BITS   = 2,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             jalr,
    input  logic             trap,
    input  logic             mret,
    input  logic             halt,
    input  logic             resume,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pcplus_4,
    output logic [XLEN-1:0]  pc_next,
    output logic             pc_valid,
    output logic             misaligned,
    output logic [XLEN-1:0]  mepc,
    output logic             halted,
    output logic [CNT_W-1:0] adv_count
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            target_bad;
    logic            pc_load;
    logic            take_trap;
    logic            fault;

    assign pcplus_4 = pc + XLEN'(4);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_BOOT;
        else      state <= state_next;
    end

    // Next-state logic. A trap wins over a simultaneous halt; the halt is
    // only honoured on a later cycle if it is still requested.
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN:  if (!trap && halt) state_next = ST_HALT;
            ST_HALT: if (resume) state_next = ST_RUN;
            default: state_next = ST_BOOT;
        endcase
    end

    // Output decode
    always_comb begin
        pc_valid = (state == ST_RUN);
        halted   = (state == ST_HALT);
    end

    // Next-PC selection. The alignment check covers only the redirect
    // targets (mret/jalr/jump/branch), and is applied after the JALR bit0 clear.
    always_comb begin
        redirect = mret | jalr | jump | branch_taken;
        if (mret)                     target = mepc;
        else if (jalr)                target = (rs1 + imm) & ~XLEN'(1);
        else if (jump | branch_taken) target = pc + imm;
        else                          target = pcplus_4;
        target_bad = redirect && ((target & ALIGN_MASK) != '0);

        pc_next   = pc;
        pc_load   = 1'b0;
        take_trap = 1'b0;
        fault     = 1'b0;
        if (state == ST_RUN) begin
            if (trap) begin
                pc_load   = 1'b1;
                take_trap = 1'b1;
                pc_next   = TRAP_VECTOR;
            end else if (!halt && !stall) begin
                pc_load = 1'b1;
                if (target_bad) begin
                    fault     = 1'b1;
                    take_trap = 1'b1;
                    pc_next   = TRAP_VECTOR;
                end else begin
                    pc_next = target;
                end
            end
        end
    end

    // Datapath registers. pc_next already equals pc whenever the PC holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_VECTOR;
            mepc       <= '0;
            adv_count  <= '0;
            misaligned <= 1'b0;
        end else begin
            pc         <= pc_next;
            misaligned <= fault;
            if (take_trap) mepc <= pc;
            if (pc_load)   adv_count <= adv_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the single-cycle RISC-V core. It is the successor of the fixed 32-bit PC + 4 / PC + imm path. It adds:
- a configurable reset vector and alignment;
- a JALR target path;
- stall and halt/resume control;
- trap and mret redirection with a saved exception PC;
- target-misalignment detection;
- an advance counter.

It sits between the control unit and instruction memory and drives the fetch address.

Parameters:
XLEN, 32, datapath and address width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned-target fault.
ALIGN_BITS, 2, number of target LSBs that must be zero (2 = RV32I, 1 = C extension).
CNT_W, 32, width of the PC-advance counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
stall  in  1  hold PC; blocks all updates except trap and halt.
branch_taken  in  1  conditional branch resolved taken, target pc+imm.
jump  in  1  JAL, target pc+imm.
jalr  in  1  JALR, target (rs1+imm) with bit0 cleared.
trap  in  1  synchronous exception or ecall, redirect to TRAP_VECTOR.
mret  in  1  return from trap, target mepc.
halt  in  1  debug halt request.
resume  in  1  leave halt state.
imm  in  XLEN  sign-extended immediate.
rs1  in  XLEN  JALR base register value.
pc  out  XLEN  current fetch address (registered).
pcplus_4  out  XLEN  pc+4 (combinational; link value).
pc_next  out  XLEN  value pc takes at next edge (combinational).
pc_valid  out  1  fetch address valid (registered state decode).
misaligned  out  1  one-cycle registered pulse: a misaligned target was rejected.
mepc  out  XLEN  saved exception PC.
halted  out  1  FSM in HALT.
adv_count  out  CNT_W  number of PC updates in RUN.

Behaviour:
- Reset (rst=0, asynchronous) sets pc=RESET_VECTOR, mepc=0, adv_count=0, misaligned=0, state=BOOT. Hence pc_valid=0 and halted=0.
- FSM states are BOOT, RUN and HALT.
  - BOOT lasts exactly one cycle after reset release. pc is held, all control inputs are ignored, then the FSM goes to RUN.
  - In RUN, pc_valid=1.
  - In HALT, pc is held, pc_valid=0 and halted=1. Only resume exits HALT, to RUN with pc unchanged. trap, mret and redirects are ignored in HALT.
- RUN next-PC priority (highest first):
  1. trap: pc_next=TRAP_VECTOR, and mepc<=pc.
  2. halt: pc held, FSM goes to HALT.
  3. stall: pc held.
  4. mret: pc_next=mepc.
  5. jalr: target = (rs1+imm) & ~1.
  6. jump or branch_taken: target = pc+imm.
  7. Otherwise: pc+4.
- trap and halt asserted together: the trap is taken. HALT is entered on the next cycle only if halt is still high.
- Misalignment check applies to priorities 4–6, after JALR bit0 masking. If target[ALIGN_BITS-1:0] != 0:
  - pc_next=TRAP_VECTOR;
  - mepc<=pc;
  - misaligned=1 in the following cycle only.
  - With ALIGN_BITS=1, JALR can never fault.
- All arithmetic is modulo 2^XLEN; overflow wraps silently. This covers pc+4 at the top of the address space and pc+imm with negative imm.
- adv_count increments on every RUN edge where pc is loaded (not held), including trap and fault redirects. It wraps to 0 at 2^CNT_W.
- pc_next equals pc whenever pc is held (BOOT, HALT, stall, halt request).
- Reset asserted mid-operation immediately forces all reset values, regardless of the FSM state or pending inputs.

Test Plan:
- Reset release, no controls, RESET_VECTOR=0 -> cycle 0 pc=0 with pc_valid=0 (BOOT); then pc=0,4,8,C with pc_valid=1 and adv_count=3 after the 3rd advance.
- pc=0x40, branch_taken=1, imm=-8 -> next pc=0x38. Same cycle with stall=1 -> pc stays 0x40 and adv_count unchanged.
- pc=0x20, jalr=1, rs1=0x1001, imm=0x2 -> target 0x1002 (bit1 set) -> pc=0x100, misaligned pulses 1 cycle, mepc=0x20. With ALIGN_BITS=1 -> pc=0x1002 and no pulse.
- pc=0x80, trap=1 and stall=1 -> pc=0x100, mepc=0x80. Two cycles later mret=1 -> pc=0x80.
- pc=0x10, halt=1 for 1 cycle -> halted=1, pc=0x10 and pc_valid=0 held for 5 cycles with jump/trap toggling. resume=1 -> RUN, next pc=0x14.
- pc=0xFFFF_FFFC, no controls -> pc wraps to 0x0. rst pulled low mid-HALT -> pc=RESET_VECTOR, halted=0 and adv_count=0 asynchronously.
